nested_struct_assembler: RTL and testbench
==========================================

// Module: nested_struct_assembler
// PURPOSE
//  Upstream feeder for nested-packed-struct consumers. Collects a record of
//  type {foo{a[A_W-1:0], b[B_W-1:0]}, bar{foo{a}}} one field per beat over a
//  valid/ready stream, then presents the packed record on a valid/ready output.
//  Sits between a serial field/config source and the struct-typed datapath.
// PARAMETERS
//  A_W  3  width of foo.a
//  B_W  4  width of foo.b
//  (derived) D_W = max(A_W,B_W) field data width; R_W = A_W+B_W+1 record width
// PORTS
//  clk        in   1    clock; all state updates on rising edge
//  rst_n      in   1    asynchronous reset, active-low
//  fld_valid  in   1    field beat valid
//  fld_ready  out  1    field beat accepted when fld_valid&&fld_ready
//  fld_sel    in   2    0=foo.a 1=foo.b 2=bar.foo.a 3=illegal
//  fld_data   in   D_W  field value, LSB-aligned
//  fld_last   in   1    final beat of the record
//  out_valid  out  1    record valid
//  out_ready  in   1    record consumed when out_valid&&out_ready
//  out_data   out  R_W  {foo.a, foo.b, bar.foo.a}, foo.a at MSBs
//  out_mask   out  3    fields written: [2]=foo.a [1]=foo.b [0]=bar.foo.a
//  out_err    out  1    record saw a duplicate field write or illegal sel
// BEHAVIOUR
//  - Reset: state=FILL, fld_ready=1, out_valid=0, out_data=0, out_mask=0,
//    out_err=0. Async assert; reset mid-record discards the partial record.
//  - FSM FILL: fld_ready=1, out_valid=0. Each accepted beat writes the field
//    named by fld_sel into the accumulator (truncated to field width, low bits
//    kept) and sets its mask bit. Accepted beat with fld_last -> HOLD.
//  - FSM HOLD: fld_ready=0, out_valid=1; out_data/out_mask/out_err stable.
//    out_valid&&out_ready -> FILL; accumulator, mask, err cleared same edge.
//  - Latency: out_valid rises the cycle after the last beat is accepted.
//    Max throughput: one record per (beats+1) cycles; no bypass.
//  - Repeated write of a field in one record: last value wins, out_err=1.
//  - fld_sel=3: beat accepted, no field changes, out_err=1; if fld_last,
//    record still completes.
//  - fld_last on the first beat is legal: unwritten fields read 0, mask shows.
//  - fld_valid while in HOLD: not accepted; source must hold the beat.
//  - out_ready while out_valid=0: ignored.
// CONFIGURATION
//  STRUCT_ASM_PARITY_EN: when defined, adds port out_par (out, 1) = XOR of
//  out_data, registered with the record, 0 in reset/FILL; HOLD also asserts
//  out_err if any mask bit is 0 (incomplete record). When undefined, no
//  out_par port; incomplete records do not flag out_err.
// TESTING  (A_W=3, B_W=4)
//  - Beats (0,3),(1,5),(2,0,last) -> next cycle out_valid=1, out_data=8'h6A,
//    out_mask=3'b111, out_err=0; fld_ready=0 until out_ready.
//  - Same record, out_ready held 0 for 5 cycles -> out_data stable, fld_valid
//    beats stalled; out_ready=1 -> FILL next cycle, mask=0.
//  - Beats (1,4'hF),(1,4'h2,last) -> out_data=8'h04, mask=3'b010, out_err=1.
//  - Beat (3,x,last) -> out_data=0, mask=0, out_err=1 (plus par=0 with EN).
//  - (0,4'hF) truncates foo.a to 3'h7; then rst_n pulse mid-record -> all
//    outputs 0, next record assembles cleanly.
//  - PARITY_EN: (2,1,last) -> out_data=8'h01, out_par=1, out_err=1.

Source files
------------

// File: rtl/nested_struct_assembler_if.sv
// ============================================================================
// Module     : nested_struct_assembler_if
// Description: Field-beat input stream and packed-record output stream.
//              Adds out_par when STRUCT_ASM_PARITY_EN is defined.
// Revision   : 1.0  initial release
// ============================================================================
`default_nettype none

interface nested_struct_assembler_if #(
   parameter int A_W = 3,
   parameter int B_W = 4,
   parameter int D_W = (A_W > B_W) ? A_W : B_W,
   parameter int R_W = A_W + B_W + 1
);
   logic           fld_valid;
   logic           fld_ready;
   logic [1:0]     fld_sel;
   logic [D_W-1:0] fld_data;
   logic           fld_last;
   logic           out_valid;
   logic           out_ready;
   logic [R_W-1:0] out_data;
   logic [2:0]     out_mask;
   logic           out_err;
`ifdef STRUCT_ASM_PARITY_EN
   logic           out_par;

   modport slave (
      input  fld_valid, fld_sel, fld_data, fld_last, out_ready,
      output fld_ready, out_valid, out_data, out_mask, out_err, out_par
   );
   modport master (
      output fld_valid, fld_sel, fld_data, fld_last, out_ready,
      input  fld_ready, out_valid, out_data, out_mask, out_err, out_par
   );
`else
   modport slave (
      input  fld_valid, fld_sel, fld_data, fld_last, out_ready,
      output fld_ready, out_valid, out_data, out_mask, out_err
   );
   modport master (
      output fld_valid, fld_sel, fld_data, fld_last, out_ready,
      input  fld_ready, out_valid, out_data, out_mask, out_err
   );
`endif
endinterface

`default_nettype wire

// File: rtl/nested_struct_assembler.sv
// ============================================================================
// Module     : nested_struct_assembler
// Description: Collects {foo.a, foo.b, bar.foo.a} one field per beat, then
//              holds the packed record until consumed. Option macro:
//              STRUCT_ASM_PARITY_EN (out_par + incomplete-record error).
// Revision   : 1.0  initial release
// ============================================================================
`default_nettype none

module nested_struct_assembler #(
   parameter int A_W = 3,
   parameter int B_W = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   nested_struct_assembler_if.slave   bus
);
   typedef enum logic [0:0] {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_t;

   localparam logic [1:0] SEL_FOO_A = 2'd0;
   localparam logic [1:0] SEL_FOO_B = 2'd1;
   localparam logic [1:0] SEL_BAR_A = 2'd2;

   state_t           state, state_nxt;
   logic [A_W-1:0]   foo_a, foo_a_nxt;
   logic [B_W-1:0]   foo_b, foo_b_nxt;
   logic             bar_a, bar_a_nxt;
   logic [2:0]       mask, mask_nxt;
   logic             err, err_nxt;
`ifdef STRUCT_ASM_PARITY_EN
   logic             par, par_nxt;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= FILL;
         foo_a <= '0;
         foo_b <= '0;
         bar_a <= 1'b0;
         mask  <= 3'b000;
         err   <= 1'b0;
`ifdef STRUCT_ASM_PARITY_EN
         par   <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         foo_a <= foo_a_nxt;
         foo_b <= foo_b_nxt;
         bar_a <= bar_a_nxt;
         mask  <= mask_nxt;
         err   <= err_nxt;
`ifdef STRUCT_ASM_PARITY_EN
         par   <= par_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt = state;
      foo_a_nxt = foo_a;
      foo_b_nxt = foo_b;
      bar_a_nxt = bar_a;
      mask_nxt  = mask;
      err_nxt   = err;
`ifdef STRUCT_ASM_PARITY_EN
      par_nxt   = par;
`endif
      case (state)
         FILL: begin
            if (bus.fld_valid) begin
               // A rewrite of an already-set field keeps the new value but flags the record.
               case (bus.fld_sel)
                  SEL_FOO_A: begin
                     foo_a_nxt   = bus.fld_data[A_W-1:0];
                     err_nxt     = err | mask[2];
                     mask_nxt[2] = 1'b1;
                  end
                  SEL_FOO_B: begin
                     foo_b_nxt   = bus.fld_data[B_W-1:0];
                     err_nxt     = err | mask[1];
                     mask_nxt[1] = 1'b1;
                  end
                  SEL_BAR_A: begin
                     bar_a_nxt   = bus.fld_data[0];
                     err_nxt     = err | mask[0];
                     mask_nxt[0] = 1'b1;
                  end
                  default: err_nxt = 1'b1;
               endcase
               if (bus.fld_last) begin
                  state_nxt = HOLD;
`ifdef STRUCT_ASM_PARITY_EN
                  par_nxt   = ^{foo_a_nxt, foo_b_nxt, bar_a_nxt};
`endif
               end
            end
         end
         HOLD: begin
            if (bus.out_ready) begin
               state_nxt = FILL;
               foo_a_nxt = '0;
               foo_b_nxt = '0;
               bar_a_nxt = 1'b0;
               mask_nxt  = 3'b000;
               err_nxt   = 1'b0;
`ifdef STRUCT_ASM_PARITY_EN
               par_nxt   = 1'b0;
`endif
            end
         end
         default: state_nxt = FILL;
      endcase
   end

   assign bus.fld_ready = (state == FILL);
   assign bus.out_valid = (state == HOLD);
   assign bus.out_data  = {foo_a, foo_b, bar_a};
   assign bus.out_mask  = mask;
`ifdef STRUCT_ASM_PARITY_EN
   assign bus.out_err   = err | ((state == HOLD) && (mask != 3'b111));
   assign bus.out_par   = par;
`else
   assign bus.out_err   = err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_nested_struct_assembler.sv
// ============================================================================
// Module     : tb_nested_struct_assembler
// Description: Directed vector table plus stall and mid-record reset sequences.
// Revision   : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_nested_struct_assembler;
   localparam int A_W = 3;
   localparam int B_W = 4;

   logic clk;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   nested_struct_assembler_if #(.A_W(A_W), .B_W(B_W)) bus ();

   nested_struct_assembler #(.A_W(A_W), .B_W(B_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      int         n;
      logic [7:0] sels;    // beat i uses sels[2*i +: 2]
      logic [15:0] datas;  // beat i uses datas[4*i +: 4]
      logic [7:0] exp_data;
      logic [2:0] exp_mask;
      logic       exp_err;
      logic       exp_err_par;
      logic       exp_par;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send_beat(input logic [1:0] sel, input logic [3:0] data, input logic last);
      int wait_cnt;
      @(negedge clk);
      bus.fld_valid = 1'b1;
      bus.fld_sel   = sel;
      bus.fld_data  = data;
      bus.fld_last  = last;
      wait_cnt = 0;
      while (!bus.fld_ready && wait_cnt < 20) begin
         @(negedge clk);
         wait_cnt++;
      end
      if (!bus.fld_ready) chk("beat_accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
   endtask

   task automatic idle_inputs();
      bus.fld_valid = 1'b0;
      bus.fld_sel   = 2'd0;
      bus.fld_data  = 4'd0;
      bus.fld_last  = 1'b0;
   endtask

   initial begin
      vecs[0] = '{"full",      3, 8'b00_10_01_00, 16'h0053, 8'h6A, 3'b111, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{"dup_b",     2, 8'b00_00_01_01, 16'h002F, 8'h04, 3'b010, 1'b1, 1'b1, 1'b1};
      vecs[2] = '{"illegal",   1, 8'b00_00_00_11, 16'h0005, 8'h00, 3'b000, 1'b1, 1'b1, 1'b0};
      vecs[3] = '{"bar_only",  1, 8'b00_00_00_10, 16'h0001, 8'h01, 3'b001, 1'b0, 1'b1, 1'b1};
      vecs[4] = '{"trunc",     3, 8'b00_10_01_00, 16'h030F, 8'hE1, 3'b111, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{"ill_mid",   4, 8'b00_01_11_10, 16'h4901, 8'h93, 3'b111, 1'b1, 1'b1, 1'b0};
      vecs[6] = '{"no_bar",    2, 8'b00_00_01_00, 16'h00A5, 8'hB4, 3'b110, 1'b0, 1'b1, 1'b0};

      idle_inputs();
      bus.out_ready = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_fld_ready", 32'(bus.fld_ready), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_data",  32'(bus.out_data),  32'd0);
      chk("rst_out_mask",  32'(bus.out_mask),  32'd0);
      chk("rst_out_err",   32'(bus.out_err),   32'd0);
`ifdef STRUCT_ASM_PARITY_EN
      chk("rst_out_par",   32'(bus.out_par),   32'd0);
`endif
      rst_n = 1'b1;

      for (int v = 0; v < 7; v++) begin
         for (int i = 0; i < vecs[v].n; i++)
            send_beat(vecs[v].sels[2*i +: 2], vecs[v].datas[4*i +: 4], (i == vecs[v].n - 1));
         @(negedge clk);
         idle_inputs();
         chk({vecs[v].name, "_valid"}, 32'(bus.out_valid), 32'd1);
         chk({vecs[v].name, "_ready"}, 32'(bus.fld_ready), 32'd0);
         chk({vecs[v].name, "_data"},  32'(bus.out_data),  32'(vecs[v].exp_data));
         chk({vecs[v].name, "_mask"},  32'(bus.out_mask),  32'(vecs[v].exp_mask));
`ifdef STRUCT_ASM_PARITY_EN
         chk({vecs[v].name, "_err"},   32'(bus.out_err),   32'(vecs[v].exp_err_par));
         chk({vecs[v].name, "_par"},   32'(bus.out_par),   32'(vecs[v].exp_par));
`else
         chk({vecs[v].name, "_err"},   32'(bus.out_err),   32'(vecs[v].exp_err));
`endif
         bus.out_ready = 1'b1;
         @(negedge clk);
         bus.out_ready = 1'b0;
         chk({vecs[v].name, "_drain_valid"}, 32'(bus.out_valid), 32'd0);
         chk({vecs[v].name, "_drain_mask"},  32'(bus.out_mask),  32'd0);
         chk({vecs[v].name, "_drain_err"},   32'(bus.out_err),   32'd0);
      end

      // Stalled output: a pending beat must wait while the record is held.
      send_beat(2'd0, 4'd3, 1'b0);
      send_beat(2'd1, 4'd5, 1'b0);
      send_beat(2'd2, 4'd0, 1'b1);
      @(negedge clk);
      bus.fld_valid = 1'b1;
      bus.fld_sel   = 2'd0;
      bus.fld_data  = 4'd7;
      bus.fld_last  = 1'b0;
      for (int c = 0; c < 5; c++) begin
         chk("stall_data",  32'(bus.out_data),  32'h6A);
         chk("stall_ready", 32'(bus.fld_ready), 32'd0);
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk("stall_release_valid", 32'(bus.out_valid), 32'd0);
      chk("stall_release_mask",  32'(bus.out_mask),  32'd0);
      chk("stall_release_ready", 32'(bus.fld_ready), 32'd1);
      @(negedge clk);
      idle_inputs();
      chk("held_beat_mask", 32'(bus.out_mask), 32'b100);
      chk("held_beat_data", 32'(bus.out_data), 32'hE0);

      // Truncated foo.a followed by a reset mid-record.
      send_beat(2'd0, 4'hF, 1'b0);
      @(negedge clk);
      idle_inputs();
      chk("trunc_partial_data", 32'(bus.out_data), 32'hE0);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_data",  32'(bus.out_data),  32'd0);
      chk("mid_rst_mask",  32'(bus.out_mask),  32'd0);
      chk("mid_rst_err",   32'(bus.out_err),   32'd0);
      chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      send_beat(2'd1, 4'h9, 1'b0);
      send_beat(2'd0, 4'h2, 1'b1);
      @(negedge clk);
      chk("post_rst_valid", 32'(bus.out_valid), 32'd1);
      chk("post_rst_data",  32'(bus.out_data),  32'h52);
      chk("post_rst_mask",  32'(bus.out_mask),  32'b110);
`ifndef STRUCT_ASM_PARITY_EN
      chk("post_rst_err",   32'(bus.out_err),   32'd0);
`else
      chk("post_rst_err",   32'(bus.out_err),   32'd1);
      chk("post_rst_par",   32'(bus.out_par),   32'd1);
`endif
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule

`default_nettype wire
